// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide engine for the Execute stage.
// Multiplies and divides sign-magnitude operands over XLEN/STEP cycles.
module muldiv_unit #(
    parameter int XLEN = 32,
    parameter int STEP = 1
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            start_i,
    input  logic            kill_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] src_a_i,
    input  logic [XLEN-1:0] src_b_i,
    output logic            stall_req_o,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);
    localparam int N  = XLEN / STEP;
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(N);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2:0]        op_q, op_d;
    logic              neg_q, neg_d;
    logic              fast_q, fast_d;
    logic [XLEN-1:0]   opb_q, opb_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   result_q, result_d;

    logic            is_div, a_sgn, b_sgn, sa, sb;
    logic            b_zero, ovf, fast, accept;
    logic [XLEN-1:0] mag_a, mag_b, fast_res;

    assign is_div = funct3_i[2];
    assign a_sgn  = is_div ? ~funct3_i[0] : (funct3_i != 3'b011);
    assign b_sgn  = is_div ? ~funct3_i[0] : ~funct3_i[1];
    assign sa     = a_sgn & src_a_i[XLEN-1];
    assign sb     = b_sgn & src_b_i[XLEN-1];
    assign mag_a  = sa ? -src_a_i : src_a_i;
    assign mag_b  = sb ? -src_b_i : src_b_i;
    assign b_zero = (src_b_i == '0);
    assign ovf    = is_div & ~funct3_i[0] & (&src_b_i)
                  & (src_a_i == {1'b1, {(XLEN-1){1'b0}}});
    assign fast   = is_div & (b_zero | ovf);
    assign accept = start_i & ~kill_i;

    always_comb begin
        fast_res = '0;
        if (b_zero)
            fast_res = funct3_i[1] ? src_a_i : '1;
        else if (!funct3_i[1])
            fast_res = src_a_i;
    end

    // Low half of acc holds the multiplier or the dividend as it shifts out.
    logic [2*XLEN:0] mul_t, div_t;

    always_comb begin
        mul_t = {1'b0, acc_q};
        div_t = {1'b0, acc_q};
        for (int i = 0; i < STEP; i++) begin
            if (mul_t[0])
                mul_t[2*XLEN:XLEN] = mul_t[2*XLEN:XLEN] + {1'b0, opb_q};
            mul_t = mul_t >> 1;
            div_t = div_t << 1;
            if (div_t[2*XLEN:XLEN] >= {1'b0, opb_q}) begin
                div_t[2*XLEN:XLEN] = div_t[2*XLEN:XLEN] - {1'b0, opb_q};
                div_t[0] = 1'b1;
            end
        end
    end

    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   dbase, res_calc;

    always_comb begin
        prod     = neg_q ? -acc_q : acc_q;
        dbase    = op_q[1] ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];
        res_calc = '0;
        if (fast_q)
            res_calc = acc_q[XLEN-1:0];
        else if (op_q[2])
            res_calc = neg_q ? -dbase : dbase;
        else if (op_q[1:0] == 2'b00)
            res_calc = prod[XLEN-1:0];
        else
            res_calc = prod[2*XLEN-1:XLEN];
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        neg_d       = neg_q;
        fast_d      = fast_q;
        opb_d       = opb_q;
        acc_d       = acc_q;
        result_d    = result_q;
        stall_req_o = 1'b0;
        done_o      = 1'b0;
        unique case (state_q)
            IDLE: begin
                stall_req_o = accept;
                if (accept) begin
                    op_d    = funct3_i;
                    neg_d   = (is_div & funct3_i[1]) ? sa : (sa ^ sb);
                    fast_d  = fast;
                    opb_d   = is_div ? mag_b : mag_a;
                    acc_d   = {{XLEN{1'b0}}, fast ? fast_res
                                           : (is_div ? mag_a : mag_b)};
                    cnt_d   = '0;
                    state_d = fast ? DONE : RUN;
                end
            end
            RUN: begin
                stall_req_o = 1'b1;
                acc_d = op_q[2] ? div_t[2*XLEN-1:0] : mul_t[2*XLEN-1:0];
                cnt_d = cnt_q + 1'b1;
                if (kill_i)
                    state_d = IDLE;
                else if (cnt_d == CNT_LAST)
                    state_d = DONE;
            end
            DONE: begin
                done_o  = ~kill_i;
                state_d = IDLE;
                if (!kill_i)
                    result_d = res_calc;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            fast_q   <= 1'b0;
            opb_q    <= '0;
            acc_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            fast_q   <= fast_d;
            opb_q    <= opb_d;
            acc_q    <= acc_d;
            result_q <= result_d;
        end
    end

    assign busy_o   = (state_q != IDLE);
    assign result_o = done_o ? res_calc : result_q;

endmodule
